// File: rtl/taxi_eth_tx_arb.sv
// ============================================================================
// taxi_eth_tx_arb
// ----------------------------------------------------------------------------
// Frame-level round-robin arbiter in front of the shared 1G MAC transmit
// stream. Whole frames from PORTS sources are merged onto one output stream,
// and each output beat is tagged with the index of its source port in tid.
// MAC transmit completions are steered back to the port named by their tid.
//
// Optional feature macro: TAXI_ETH_TX_ARB_WATCHDOG_EN
//   When defined, a granted source that stalls mid-frame for TIMEOUT cycles
//   has its frame cut short. The arbiter emits one error beat (tlast=1,
//   tuser=1), discards the rest of the source's frame, and pulses stat_abort.
//   When undefined, a grant is held until tlast, however long that takes.
//
// Ports:
//   clk, rst_n               transmit clock, asynchronous active-low reset
//   s_axis_tx_*   [PORTS]    per-source frame streams (tdata/tkeep/tlast/
//                            tuser/tvalid in, tready out)
//   m_axis_tx_*              merged stream to the MAC (tid = source index)
//   s_axis_tx_cpl_*          completions from the MAC
//   m_axis_tx_cpl_* [PORTS]  per-port completions (tdata/tid broadcast,
//                            tvalid steered by tid)
//   grant_valid, grant_idx   current output owner
//   stat_abort               one-cycle pulse per watchdog abort
// ============================================================================
module taxi_eth_tx_arb #(
    parameter int  PORTS   = 4,
    parameter int  DATA_W  = 8,
    parameter int  ID_W    = 8,
    parameter int  CPL_W   = 96,
    parameter int  TIMEOUT = 1024,
    localparam int IDX_W   = $clog2(PORTS),
    localparam int KEEP_W  = (DATA_W + 7) / 8
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [PORTS-1:0][DATA_W-1:0]     s_axis_tx_tdata,
    input  logic [PORTS-1:0][KEEP_W-1:0]     s_axis_tx_tkeep,
    input  logic [PORTS-1:0]                 s_axis_tx_tvalid,
    input  logic [PORTS-1:0]                 s_axis_tx_tlast,
    input  logic [PORTS-1:0]                 s_axis_tx_tuser,
    output logic [PORTS-1:0]                 s_axis_tx_tready,

    output logic [DATA_W-1:0]                m_axis_tx_tdata,
    output logic [KEEP_W-1:0]                m_axis_tx_tkeep,
    output logic                             m_axis_tx_tvalid,
    output logic                             m_axis_tx_tlast,
    output logic                             m_axis_tx_tuser,
    output logic [ID_W-1:0]                  m_axis_tx_tid,
    input  logic                             m_axis_tx_tready,

    input  logic [CPL_W-1:0]                 s_axis_tx_cpl_tdata,
    input  logic [ID_W-1:0]                  s_axis_tx_cpl_tid,
    input  logic                             s_axis_tx_cpl_tvalid,
    output logic                             s_axis_tx_cpl_tready,

    output logic [PORTS-1:0][CPL_W-1:0]      m_axis_tx_cpl_tdata,
    output logic [PORTS-1:0][ID_W-1:0]       m_axis_tx_cpl_tid,
    output logic [PORTS-1:0]                 m_axis_tx_cpl_tvalid,
    input  logic [PORTS-1:0]                 m_axis_tx_cpl_tready,

    output logic                             grant_valid,
    output logic [IDX_W-1:0]                 grant_idx,
    output logic                             stat_abort
);

    if (ID_W < IDX_W) begin : g_bad_id_w
        $error("taxi_eth_tx_arb: ID_W must be at least $clog2(PORTS)");
    end
    if (PORTS < 2 || PORTS > 16) begin : g_bad_ports
        $error("taxi_eth_tx_arb: PORTS must be in 2..16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("taxi_eth_tx_arb: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS
`ifdef TAXI_ETH_TX_ARB_WATCHDOG_EN
        , ST_ABORT,
        ST_DRAIN
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [KEEP_W-1:0]   m_keep_q, m_keep_d;
    logic                m_last_q, m_last_d;
    logic                m_user_q, m_user_d;
    logic [ID_W-1:0]     m_id_q, m_id_d;
    logic [PORTS-1:0]    src_ready;
    logic                out_free;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

`ifdef TAXI_ETH_TX_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                started_q, started_d;
    logic                abort_q, abort_d;
`endif

    // The output register can take a new beat when it is empty or its
    // current beat leaves this cycle.
    assign out_free = !m_valid_q || m_axis_tx_tready;

    // Round-robin search: scan ports starting just after the last winner,
    // wrapping past PORTS-1 back to 0. PORTS need not be a power of two,
    // so the wrap is done explicitly rather than by bit truncation.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= PORTS; k++) begin
            int j;
            j = int'(last_q) + k;
            if (j >= PORTS) begin
                j = j - PORTS;
            end
            if (!pick_found && s_axis_tx_tvalid[j]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
    end

    // Next-state logic for the grant FSM and the single output register.
    // Only the granted source ever sees tready; a beat accepted from it is
    // loaded straight into the output register and tagged with its index.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        m_user_d  = m_user_q;
        m_id_d    = m_id_q;
        src_ready = '0;
`ifdef TAXI_ETH_TX_ARB_WATCHDOG_EN
        cnt_d     = cnt_q;
        started_d = started_q;
        abort_d   = 1'b0;
`endif
        if (m_axis_tx_tready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
`ifdef TAXI_ETH_TX_ARB_WATCHDOG_EN
                cnt_d     = '0;
                started_d = 1'b0;
`endif
                if (pick_found) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = ST_PASS;
                end
            end

            ST_PASS: begin
                src_ready[grant_q] = out_free;
                if (s_axis_tx_tvalid[grant_q] && out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_axis_tx_tdata[grant_q];
                    m_keep_d  = s_axis_tx_tkeep[grant_q];
                    m_last_d  = s_axis_tx_tlast[grant_q];
                    m_user_d  = s_axis_tx_tuser[grant_q];
                    m_id_d    = ID_W'(grant_q);
                    if (s_axis_tx_tlast[grant_q]) begin
                        state_d = ST_IDLE;
                    end
`ifdef TAXI_ETH_TX_ARB_WATCHDOG_EN
                    cnt_d     = '0;
                    started_d = 1'b1;
                end else if (started_q && !s_axis_tx_tvalid[grant_q]) begin
                    // Only source-side starvation counts; output backpressure
                    // with tvalid held high is not a stall.
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        cnt_d   = '0;
                        abort_d = 1'b1;
                        state_d = ST_ABORT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end

`ifdef TAXI_ETH_TX_ARB_WATCHDOG_EN
            // Terminate the truncated frame downstream with an error beat.
            ST_ABORT: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = '0;
                    m_keep_d  = '1;
                    m_last_d  = 1'b1;
                    m_user_d  = 1'b1;
                    m_id_d    = ID_W'(grant_q);
                    state_d   = ST_DRAIN;
                end
            end

            // Swallow whatever is left of the aborted source frame.
            ST_DRAIN: begin
                src_ready[grant_q] = 1'b1;
                if (s_axis_tx_tvalid[grant_q] && s_axis_tx_tlast[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. last_q resets to the top index so that
    // port 0 wins the first arbitration after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_q    <= IDX_W'(PORTS - 1);
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
            m_id_q    <= '0;
`ifdef TAXI_ETH_TX_ARB_WATCHDOG_EN
            cnt_q     <= '0;
            started_q <= 1'b0;
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
            m_user_q  <= m_user_d;
            m_id_q    <= m_id_d;
`ifdef TAXI_ETH_TX_ARB_WATCHDOG_EN
            cnt_q     <= cnt_d;
            started_q <= started_d;
            abort_q   <= abort_d;
`endif
        end
    end

    assign s_axis_tx_tready = src_ready;
    assign m_axis_tx_tvalid = m_valid_q;
    assign m_axis_tx_tdata  = m_data_q;
    assign m_axis_tx_tkeep  = m_keep_q;
    assign m_axis_tx_tlast  = m_last_q;
    assign m_axis_tx_tuser  = m_user_q;
    assign m_axis_tx_tid    = m_id_q;
    assign grant_valid      = (state_q != ST_IDLE);
    assign grant_idx        = grant_q;
`ifdef TAXI_ETH_TX_ARB_WATCHDOG_EN
    assign stat_abort       = abort_q;
`else
    assign stat_abort       = 1'b0;
`endif

    // Completion steering. The full tid is range-checked, not just its low
    // bits, so an out-of-range tid is never aliased onto a real port; such
    // completions are consumed and dropped.
    logic             cpl_in_range;
    logic [IDX_W-1:0] cpl_sel;

    assign cpl_in_range = ({1'b0, s_axis_tx_cpl_tid} < (ID_W + 1)'(PORTS));
    assign cpl_sel      = s_axis_tx_cpl_tid[IDX_W-1:0];

    always_comb begin
        m_axis_tx_cpl_tvalid = '0;
        s_axis_tx_cpl_tready = 1'b1;
        if (cpl_in_range) begin
            m_axis_tx_cpl_tvalid[cpl_sel] = s_axis_tx_cpl_tvalid;
            s_axis_tx_cpl_tready          = m_axis_tx_cpl_tready[cpl_sel];
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_cpl_bcast
        assign m_axis_tx_cpl_tdata[p] = s_axis_tx_cpl_tdata;
        assign m_axis_tx_cpl_tid[p]   = s_axis_tx_cpl_tid;
    end

endmodule

// File: tb/tb_taxi_eth_tx_arb.sv
// ============================================================================
// tb_taxi_eth_tx_arb
// ----------------------------------------------------------------------------
// Self-checking bench for taxi_eth_tx_arb (PORTS=4, DATA_W=8, ID_W=8,
// CPL_W=96, TIMEOUT=16). Sources are modelled as per-port beat lists; every
// output beat is captured and compared frame by frame against the source
// lists in the order a plain round-robin over pending ports predicts.
// The watchdog sequence is compiled only with TAXI_ETH_TX_ARB_WATCHDOG_EN.
// ============================================================================
module tb_taxi_eth_tx_arb;

    localparam int P      = 4;
    localparam int DW     = 8;
    localparam int IW     = 8;
    localparam int CW     = 96;
    localparam int MAXB   = 512;
    localparam int MAXO   = 1024;

    logic                  clk;
    logic                  rst_n;
    logic [P-1:0][DW-1:0]  s_tdata;
    logic [P-1:0][0:0]     s_tkeep;
    logic [P-1:0]          s_tvalid, s_tlast, s_tuser, s_tready;
    logic [DW-1:0]         m_tdata;
    logic [0:0]            m_tkeep;
    logic                  m_tvalid, m_tlast, m_tuser, m_tready;
    logic [IW-1:0]         m_tid;
    logic [CW-1:0]         s_cpl_tdata;
    logic [IW-1:0]         s_cpl_tid;
    logic                  s_cpl_tvalid, s_cpl_tready;
    logic [P-1:0][CW-1:0]  m_cpl_tdata;
    logic [P-1:0][IW-1:0]  m_cpl_tid;
    logic [P-1:0]          m_cpl_tvalid, m_cpl_tready;
    logic                  grant_valid;
    logic [1:0]            grant_idx;
    logic                  stat_abort;

    taxi_eth_tx_arb #(
        .PORTS(P), .DATA_W(DW), .ID_W(IW), .CPL_W(CW), .TIMEOUT(16)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .s_axis_tx_tdata      (s_tdata),
        .s_axis_tx_tkeep      (s_tkeep),
        .s_axis_tx_tvalid     (s_tvalid),
        .s_axis_tx_tlast      (s_tlast),
        .s_axis_tx_tuser      (s_tuser),
        .s_axis_tx_tready     (s_tready),
        .m_axis_tx_tdata      (m_tdata),
        .m_axis_tx_tkeep      (m_tkeep),
        .m_axis_tx_tvalid     (m_tvalid),
        .m_axis_tx_tlast      (m_tlast),
        .m_axis_tx_tuser      (m_tuser),
        .m_axis_tx_tid        (m_tid),
        .m_axis_tx_tready     (m_tready),
        .s_axis_tx_cpl_tdata  (s_cpl_tdata),
        .s_axis_tx_cpl_tid    (s_cpl_tid),
        .s_axis_tx_cpl_tvalid (s_cpl_tvalid),
        .s_axis_tx_cpl_tready (s_cpl_tready),
        .m_axis_tx_cpl_tdata  (m_cpl_tdata),
        .m_axis_tx_cpl_tid    (m_cpl_tid),
        .m_axis_tx_cpl_tvalid (m_cpl_tvalid),
        .m_axis_tx_cpl_tready (m_cpl_tready),
        .grant_valid          (grant_valid),
        .grant_idx            (grant_idx),
        .stat_abort           (stat_abort)
    );

    // 125 MHz transmit clock.
    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Hard stop in case something upstream of the bounded loops wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1, "[TB] simulation time limit");
    end

    int vectors    = 0;
    int miscompares = 0;

    // Source model: per-port beat lists with read pointers.
    logic [DW-1:0] srcData [P][MAXB];
    bit            srcLast [P][MAXB];
    int            srcCnt  [P];
    int            srcPtr  [P];
    bit            presented [P];
    bit            midFrame  [P];
    bit            gapEn;
    bit            randReady;
    int            stallPort, stallAt, stallLeft;

    // Captured output beats.
    logic [DW-1:0] outData [MAXO];
    bit            outLast [MAXO];
    bit            outUser [MAXO];
    logic [IW-1:0] outTid  [MAXO];
    int            outCyc  [MAXO];
    int            outCnt;
    int            cyc;
    int            aborts;
    bit            holdChk;
    logic [18:0]   held;

    int            expOrder [64];
    int            expOrderN;

    typedef struct {
        logic [IW-1:0] tid;
        logic          vld;
        logic [P-1:0]  rdy;
        logic [P-1:0]  expVld;
        logic          expRdy;
    } cplVec_t;
    localparam int NCPL = 10;
    cplVec_t cplTab [NCPL];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addFrame(input int p, input int len);
        for (int i = 0; i < len; i++) begin
            srcData[p][srcCnt[p]] = 8'($urandom);
            srcLast[p][srcCnt[p]] = (i == len - 1);
            srcCnt[p]++;
        end
    endtask

    task automatic applyReset();
        rst_n        = 1'b0;
        s_tvalid     = '0;
        s_tdata      = '0;
        s_tlast      = '0;
        s_tuser      = '0;
        s_tkeep      = '1;
        m_tready     = 1'b1;
        s_cpl_tvalid = 1'b0;
        s_cpl_tid    = '0;
        s_cpl_tdata  = '0;
        m_cpl_tready = '0;
        gapEn = 0; randReady = 0; stallPort = -1; stallAt = 0; stallLeft = 0;
        for (int p = 0; p < P; p++) begin
            srcCnt[p] = 0; srcPtr[p] = 0; presented[p] = 0; midFrame[p] = 0;
        end
        outCnt = 0; cyc = 0; aborts = 0; holdChk = 0; held = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock cycle: drive sources and sink tready just after the edge,
    // sample handshakes at the falling edge, then advance to the next edge.
    task automatic applyStimulus();
        for (int p = 0; p < P; p++) begin
            s_tvalid[p] = 1'b0;
            s_tdata[p]  = '0;
            s_tlast[p]  = 1'b0;
            if (srcPtr[p] < srcCnt[p]) begin
                if (presented[p]) begin
                    s_tvalid[p] = 1'b1;
                end else if (p == stallPort && srcPtr[p] == stallAt && stallLeft > 0) begin
                    stallLeft--;
                end else if (!(midFrame[p] && gapEn && $urandom_range(0, 2) == 0)) begin
                    s_tvalid[p]  = 1'b1;
                    presented[p] = 1'b1;
                end
                if (s_tvalid[p]) begin
                    s_tdata[p] = srcData[p][srcPtr[p]];
                    s_tlast[p] = srcLast[p][srcPtr[p]];
                end
            end
        end
        m_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (holdChk) begin
            checkOutput("hold_stable", {m_tvalid, m_tdata, m_tid, m_tlast, m_tuser}, held);
        end
        holdChk = m_tvalid && !m_tready;
        held    = {m_tvalid, m_tdata, m_tid, m_tlast, m_tuser};
        if (m_tvalid && m_tready && outCnt < MAXO) begin
            outData[outCnt] = m_tdata;
            outLast[outCnt] = m_tlast;
            outUser[outCnt] = m_tuser;
            outTid[outCnt]  = m_tid;
            outCyc[outCnt]  = cyc;
            outCnt++;
        end
        if (stat_abort) aborts++;
        for (int p = 0; p < P; p++) begin
            if (s_tvalid[p] && s_tready[p]) begin
                midFrame[p]  = !srcLast[p][srcPtr[p]];
                srcPtr[p]++;
                presented[p] = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    function automatic bit allDone();
        bit d;
        d = !m_tvalid;
        for (int p = 0; p < P; p++) if (srcPtr[p] < srcCnt[p]) d = 0;
        return d;
    endfunction

    task automatic runUntilDone(input string tag, input int maxCyc);
        int n;
        n = 0;
        while (!allDone() && n < maxCyc) begin
            applyStimulus();
            n++;
        end
        checkOutput($sformatf("%s_completed", tag), allDone(), 1);
    endtask

    task automatic setOrder(input int n, input int a, input int b, input int c, input int d);
        expOrderN = n;
        expOrder[0] = a; expOrder[1] = b; expOrder[2] = c; expOrder[3] = d;
    endtask

    // Reference order: every port with frames left requests at every
    // arbitration, so the winners simply rotate over ports with work left.
    task automatic modelOrder();
        int rem [P];
        int last, total;
        total = 0;
        for (int p = 0; p < P; p++) begin
            rem[p] = 0;
            for (int i = 0; i < srcCnt[p]; i++) if (srcLast[p][i]) rem[p]++;
            total += rem[p];
        end
        last = P - 1;
        expOrderN = 0;
        for (int f = 0; f < total; f++) begin
            bit found;
            found = 0;
            for (int k = 1; k <= P; k++) begin
                int j;
                j = (last + k) % P;
                if (!found && rem[j] > 0) begin
                    found = 1;
                    rem[j]--;
                    last = j;
                    expOrder[expOrderN] = j;
                    expOrderN++;
                end
            end
        end
    endtask

    // Walk captured beats frame by frame against the expected port order.
    task automatic checkFrames(input string tag);
        int o;
        int ptr [P];
        o = 0;
        for (int p = 0; p < P; p++) ptr[p] = 0;
        for (int f = 0; f < expOrderN; f++) begin
            int p;
            bit ok, done;
            int tidSeen;
            p = expOrder[f]; ok = 1; done = 0;
            tidSeen = (o < outCnt) ? int'(outTid[o]) : -1;
            while (!done) begin
                if (o >= outCnt || ptr[p] >= srcCnt[p]) begin
                    ok = 0; done = 1;
                end else begin
                    if (outData[o] !== srcData[p][ptr[p]] || outLast[o] !== srcLast[p][ptr[p]] ||
                        outUser[o] !== 1'b0 || int'(outTid[o]) != p) ok = 0;
                    done = srcLast[p][ptr[p]];
                    o++;
                    ptr[p]++;
                end
            end
            checkOutput($sformatf("%s_frame%0d_tid", tag, f), tidSeen, p);
            checkOutput($sformatf("%s_frame%0d_data", tag, f), ok, 1);
        end
        checkOutput($sformatf("%s_beat_count", tag), outCnt, o);
    endtask

    initial begin
        // Completion steering vectors: tid, tvalid, per-port tready,
        // expected per-port tvalid, expected upstream tready.
        cplTab[0] = '{8'd1,   1'b1, 4'b1111, 4'b0010, 1'b1};
        cplTab[1] = '{8'd3,   1'b1, 4'b0111, 4'b1000, 1'b0};
        cplTab[2] = '{8'd3,   1'b1, 4'b1000, 4'b1000, 1'b1};
        cplTab[3] = '{8'd7,   1'b1, 4'b0000, 4'b0000, 1'b1};
        cplTab[4] = '{8'd0,   1'b0, 4'b0001, 4'b0000, 1'b1};
        cplTab[5] = '{8'd2,   1'b1, 4'b1011, 4'b0100, 1'b0};
        cplTab[6] = '{8'd4,   1'b1, 4'b0000, 4'b0000, 1'b1};
        cplTab[7] = '{8'd255, 1'b1, 4'b0000, 4'b0000, 1'b1};
        cplTab[8] = '{8'd1,   1'b0, 4'b0000, 4'b0000, 1'b0};
        cplTab[9] = '{8'd0,   1'b1, 4'b0001, 4'b0001, 1'b1};

        applyReset();
        checkOutput("rst_m_tvalid", m_tvalid, 0);
        checkOutput("rst_grant_valid", grant_valid, 0);
        checkOutput("rst_grant_idx", grant_idx, 0);
        checkOutput("rst_stat_abort", stat_abort, 0);
        checkOutput("rst_s_tready", s_tready, 0);

        // Completion path (combinational).
        for (int i = 0; i < NCPL; i++) begin
            s_cpl_tid    = cplTab[i].tid;
            s_cpl_tvalid = cplTab[i].vld;
            m_cpl_tready = cplTab[i].rdy;
            s_cpl_tdata  = {$urandom, $urandom, $urandom};
            #1;
            checkOutput($sformatf("cpl%0d_tvalid", i), m_cpl_tvalid, cplTab[i].expVld);
            checkOutput($sformatf("cpl%0d_tready", i), s_cpl_tready, cplTab[i].expRdy);
            if (cplTab[i].tid < P) begin
                checkOutput($sformatf("cpl%0d_tdata", i), m_cpl_tdata[cplTab[i].tid[1:0]], s_cpl_tdata);
                checkOutput($sformatf("cpl%0d_tid", i), m_cpl_tid[cplTab[i].tid[1:0]], s_cpl_tid);
            end
        end
        s_cpl_tvalid = 1'b0;
        @(posedge clk);
        #1;

        // Four simultaneous 64-byte frames at full rate.
        applyReset();
        for (int p = 0; p < P; p++) addFrame(p, 64);
        runUntilDone("full", 600);
        checkOutput("full_first_out_cycle", (outCnt > 0) ? outCyc[0] : -1, 2);
        checkOutput("full_last_out_cycle", (outCnt > 0) ? outCyc[outCnt - 1] : -1, 260);
        setOrder(4, 0, 1, 2, 3);
        checkFrames("full");

        // Port 2 streaming, port 0 requests once mid-frame.
        applyReset();
        addFrame(2, 6);
        addFrame(2, 6);
        runCycles(1);
        checkOutput("stream_grant_valid", grant_valid, 1);
        checkOutput("stream_grant_idx", grant_idx, 2);
        runCycles(2);
        addFrame(0, 4);
        runUntilDone("stream", 200);
        setOrder(3, 2, 0, 2, 0);
        checkFrames("stream");

        // Randomized frames with output backpressure and source gaps.
        for (int it = 0; it < 5; it++) begin
            int tot;
            applyReset();
            gapEn     = 1;
            randReady = 1;
            tot = 0;
            for (int p = 0; p < P; p++) begin
                int nf;
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) addFrame(p, (it == 0) ? 3 : $urandom_range(1, 6));
                tot += nf;
            end
            if (tot == 0) addFrame(0, 3);
            modelOrder();
            runUntilDone($sformatf("rand%0d", it), 2000);
            checkFrames($sformatf("rand%0d", it));
        end

        // Reset asserted in the middle of a frame from port 1.
        applyReset();
        addFrame(1, 10);
        runCycles(4);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_m_tvalid", m_tvalid, 0);
        checkOutput("midrst_grant_valid", grant_valid, 0);
        checkOutput("midrst_s_tready", s_tready, 0);
        applyReset();
        addFrame(0, 2);
        addFrame(2, 2);
        runCycles(1);
        checkOutput("midrst_first_grant", grant_idx, 0);
        runUntilDone("midrst", 100);
        setOrder(2, 0, 2, 0, 0);
        checkFrames("midrst");

`ifdef TAXI_ETH_TX_ARB_WATCHDOG_EN
        // Port 1 stalls 20 cycles after 10 beats; TIMEOUT is 16.
        applyReset();
        addFrame(1, 15);
        addFrame(2, 3);
        stallPort = 1;
        stallAt   = 10;
        stallLeft = 20;
        runUntilDone("wdog", 300);
        checkOutput("wdog_abort_pulses", aborts, 1);
        checkOutput("wdog_out_count", outCnt, 14);
        checkOutput("wdog_port1_drained", srcPtr[1], 15);
        if (outCnt >= 14) begin
            bit ok;
            ok = 1;
            for (int i = 0; i < 10; i++)
                if (outData[i] !== srcData[1][i] || outTid[i] != 8'd1 || outLast[i]) ok = 0;
            checkOutput("wdog_head_beats", ok, 1);
            checkOutput("wdog_abort_beat", {outData[10], outLast[10], outUser[10], outTid[10]},
                        {8'h00, 1'b1, 1'b1, 8'd1});
            ok = 1;
            for (int i = 0; i < 3; i++)
                if (outData[11 + i] !== srcData[2][i] || outTid[11 + i] != 8'd2) ok = 0;
            checkOutput("wdog_next_port2", ok, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
